// File: rtl/cache_req_driver.sv
// Initiator toward the DRAM row cache: queues row requests, plays them out with fixed
// RD/WR assertion timing, honours hold and returns the captured cache row upstream.
module cache_req_driver #(
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = 17,
    parameter int ASSERTCYC = 3,
    parameter int GAPCYC    = 1,
    parameter int QDEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic                 sync_req,
    output logic                 RD,
    output logic                 WR,
    output logic [ADDRWIDTH-1:0] RowId,
    output logic                 sync,
    input  logic                 hold,
    input  logic [CHWIDTH-1:0]   cRowId,
    output logic                 rsp_valid,
    output logic                 rsp_wr,
    output logic [ADDRWIDTH-1:0] rsp_row,
    output logic [CHWIDTH-1:0]   rsp_crow,
    output logic                 busy
);

    localparam int PTRW = $clog2(QDEPTH);
    localparam logic [PTRW:0]   QFULL      = (PTRW+1)'(QDEPTH);
    localparam logic [PTRW:0]   CNTONE     = (PTRW+1)'(1);
    localparam logic [PTRW-1:0] PTRONE     = PTRW'(1);
    localparam logic [3:0]      ASSERTLOAD = 4'(ASSERTCYC - 1);
    localparam logic [3:0]      GAPLOAD    = 4'((GAPCYC > 0) ? GAPCYC - 1 : 0);
    localparam bit              HASGAP     = (GAPCYC > 0);

    typedef enum logic [1:0] {IDLE, SYNC, ISSUE, GAP} state_t;

    state_t               state, state_next;
    logic [3:0]           cnt, cnt_next;
    logic [ADDRWIDTH:0]   q_mem [QDEPTH];
    logic [ADDRWIDTH:0]   head;
    logic [PTRW-1:0]      wr_ptr, rd_ptr;
    logic [PTRW:0]        q_count;
    logic                 push, pop, capture;
    logic                 sync_pend, cur_wr, rsp_pend;

    // No bypass: a full queue refuses a push even when a pop happens the same cycle.
    assign req_ready = (q_count != QFULL);
    assign push      = req_valid && req_ready;
    assign head      = q_mem[rd_ptr];
    assign busy      = (state != IDLE) || (q_count != '0);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!hold) begin
                    if (sync_pend) begin
                        state_next = SYNC;
                    end else if (q_count != '0) begin
                        pop        = 1'b1;
                        cnt_next   = ASSERTLOAD;
                        state_next = ISSUE;
                    end
                end
            end
            SYNC: begin
                state_next = HASGAP ? GAP : IDLE;
                cnt_next   = GAPLOAD;
            end
            ISSUE: begin
                if (!hold) begin
                    if (cnt == 4'd0) begin
                        capture    = 1'b1;
                        state_next = HASGAP ? GAP : IDLE;
                        cnt_next   = GAPLOAD;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
                end
            end
            GAP: begin
                if (cnt == 4'd0) state_next = IDLE;
                else             cnt_next   = cnt - 4'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= {req_wr, req_row};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRONE;
            if (pop)  rd_ptr <= rd_ptr + PTRONE;
            if (push && !pop)      q_count <= q_count + CNTONE;
            else if (pop && !push) q_count <= q_count - CNTONE;
        end
    end

    // Cache-facing strobes follow the state one cycle later, so RowId is settled before RD/WR rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RD        <= 1'b0;
            WR        <= 1'b0;
            sync      <= 1'b0;
            RowId     <= '0;
            cur_wr    <= 1'b0;
            sync_pend <= 1'b0;
            rsp_pend  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_row   <= '0;
            rsp_crow  <= '0;
        end else begin
            RD        <= (state == ISSUE) && !cur_wr;
            WR        <= (state == ISSUE) && cur_wr;
            sync      <= (state == SYNC);
            rsp_pend  <= capture;
            rsp_valid <= rsp_pend;
            if (pop) begin
                RowId  <= head[ADDRWIDTH-1:0];
                cur_wr <= head[ADDRWIDTH];
            end
            if (capture) begin
                rsp_crow <= cRowId;
                rsp_row  <= RowId;
                rsp_wr   <= cur_wr;
            end
            if (state == SYNC)  sync_pend <= 1'b0;
            else if (sync_req)  sync_pend <= 1'b1;
        end
    end

endmodule
